// File: rtl/abm_ram_slave_if.sv
// -----------------------------------------------------------------------------
// abm_ram_slave_if
//
// AXI4 memory-mapped bus bundle used between a data-mover master and the ABM
// RAM slave. It carries the five AXI4 channels:
//   AW : awaddr/awlen/awsize/awburst/awid, awlock/awcache/awqos/awprot,
//        awvalid -> awready
//   W  : wdata/wstrb/wlast, wvalid -> wready
//   B  : bresp/bid, bvalid -> bready
//   AR : araddr/arlen/arsize/arburst/arid, arlock/arcache/arqos/arprot,
//        arvalid -> arready
//   R  : rdata/rresp/rid/rlast, rvalid -> rready
// Modports: master (drives requests, write data and ready on B/R) and
// slave (drives the ready signals, B and R).
// -----------------------------------------------------------------------------
interface abm_ram_slave_if #(
    parameter int DW = 512,
    parameter int AW = 64
);
    // Write address channel
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [3:0]      awid;
    logic            awlock;
    logic [3:0]      awcache;
    logic [3:0]      awqos;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    // Write data channel
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    // Write response channel
    logic [1:0]      bresp;
    logic [3:0]      bid;
    logic            bvalid;
    logic            bready;

    // Read address channel
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [3:0]      arid;
    logic            arlock;
    logic [3:0]      arcache;
    logic [3:0]      arqos;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    // Read data channel
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic [3:0]      rid;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arid, arlock, arcache, arqos, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rid, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awqos, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arid, arlock, arcache, arqos, arprot, arvalid,
        output arready,
        output rdata, rresp, rid, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/abm_ram_slave.sv
// -----------------------------------------------------------------------------
// abm_ram_slave
//
// AXI4 slave that owns the ABM RAM buffer. INCR write bursts from a data-mover
// master land in an on-chip dual-port RAM; INCR read bursts are served back
// out through a 2-entry output buffer so reads stream at full rate even when
// RREADY stalls. Write and read channels are independent, each with one burst
// outstanding.
//
// Ports:
//   clk    - sole clock
//   reset  - asynchronous, active-high reset
//   s_axi  - abm_ram_slave_if.slave: AW/W/B/AR/R channels
//
// Behaviour notes:
//   - Word index comes from addr[log2(RAM_BYTES)-1 : log2(DW/8)]; low address
//     bits, AxSIZE and AxBURST are ignored and every burst advances DW/8 bytes
//     per beat.
//   - Beats whose byte address is >= RAM_BYTES are not written (write) or
//     return zero data (read) and report SLVERR.
//   - Write burst length is taken from WLAST only; AWLEN is not checked.
//   - A read and a write to the same word in the same cycle return old data.
// -----------------------------------------------------------------------------
module abm_ram_slave #(
    parameter int          DW        = 512,
    parameter int          AW        = 64,
    parameter int unsigned RAM_BYTES = 32'h10_0000
) (
    input  logic           clk,
    input  logic           reset,
    abm_ram_slave_if.slave s_axi
);

    localparam int NB        = DW / 8;
    localparam int BYTE_BITS = $clog2(NB);
    localparam int RAM_ABITS = $clog2(RAM_BYTES);
    localparam int IDX_W     = RAM_ABITS - BYTE_BITS;
    localparam int DEPTH     = int'(RAM_BYTES) / NB;

    localparam logic [AW-1:0] BEAT_BYTES = AW'(NB);
    localparam logic [AW-1:0] RAM_LIMIT  = AW'(RAM_BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];

    // Address-ready is held low until the first clock edge after reset so that
    // the slave never advertises acceptance while reset is still settling.
    logic live;

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) live <= 1'b0;
        else       live <= 1'b1;
    end

    // -------------------------------------------------------------------------
    // Write channel
    // -------------------------------------------------------------------------
    w_state_t         w_state, w_state_nxt;
    logic [AW-1:0]    w_addr;
    logic [3:0]       w_id;
    logic             w_err;
    logic             w_oor;
    logic [IDX_W-1:0] w_idx;
    logic             awready, wready, bvalid;
    logic             aw_hs, w_hs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready = live;
                if (live && s_axi.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (s_axi.wvalid && s_axi.wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = awready && s_axi.awvalid;
    assign w_hs  = wready && s_axi.wvalid;
    assign w_oor = (w_addr >= RAM_LIMIT);
    assign w_idx = w_addr[RAM_ABITS-1:BYTE_BITS];

    // The address is stored aligned so range checks and increments work on
    // whole beats; the error flag is sticky for the rest of the burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_addr <= '0;
            w_id   <= '0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_addr <= {s_axi.awaddr[AW-1:BYTE_BITS], {BYTE_BITS{1'b0}}};
            w_id   <= s_axi.awid;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_addr <= w_addr + BEAT_BYTES;
            if (w_oor) w_err <= 1'b1;
        end
    end

    // NOTE: the RAM array has no reset; its contents survive reset and it
    // maps onto block RAM only when left unreset.
    always_ff @(posedge clk) begin
        if (w_hs && !w_oor) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.bid     = w_id;

    // -------------------------------------------------------------------------
    // Read channel
    // -------------------------------------------------------------------------
    r_state_t         r_state, r_state_nxt;
    logic [AW-1:0]    r_addr;
    logic [8:0]       r_remaining;
    logic [3:0]       r_id;
    logic             r_oor;
    logic [IDX_W-1:0] r_idx;
    logic             arready;
    logic             ar_hs, r_hs, rd_issue, rvalid;

    // Output buffer: the RAM read register is the FIFO slot itself, so a read
    // issued in one cycle is visible at the head in the next.
    logic [DW-1:0]    fifo_data [2];
    logic [1:0][1:0]  fifo_resp;
    logic [1:0]       fifo_last;
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                arready = live;
                if (live && s_axi.arvalid) r_state_nxt = R_BURST;
            end
            R_BURST: begin
                if (r_hs && fifo_last[rd_ptr]) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs    = arready && s_axi.arvalid;
    assign rvalid   = (fifo_count != 2'd0);
    assign r_hs     = rvalid && s_axi.rready;
    assign r_oor    = (r_addr >= RAM_LIMIT);
    assign r_idx    = r_addr[RAM_ABITS-1:BYTE_BITS];
    // A slot is only claimed when one is free right now, so the buffer can
    // never overflow regardless of RREADY.
    assign rd_issue = (r_state == R_BURST) && (r_remaining != 9'd0) && (fifo_count != 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_id        <= '0;
        end else if (ar_hs) begin
            r_addr      <= {s_axi.araddr[AW-1:BYTE_BITS], {BYTE_BITS{1'b0}}};
            r_remaining <= {1'b0, s_axi.arlen} + 9'd1;
            r_id        <= s_axi.arid;
        end else if (rd_issue) begin
            r_addr      <= r_addr + BEAT_BYTES;
            r_remaining <= r_remaining - 9'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_resp  <= '0;
            fifo_last  <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (rd_issue) begin
                fifo_resp[wr_ptr] <= r_oor ? RESP_SLVERR : RESP_OKAY;
                fifo_last[wr_ptr] <= (r_remaining == 9'd1);
                wr_ptr            <= ~wr_ptr;
            end
            if (r_hs) rd_ptr <= ~rd_ptr;
            unique case ({rd_issue, r_hs})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // RAM read port; the data slot is left unreset like the array it reads.
    always_ff @(posedge clk) begin
        if (rd_issue) fifo_data[wr_ptr] <= mem[r_idx];
    end

    assign s_axi.arready = arready;
    assign s_axi.rvalid  = rvalid;
    // Error beats and idle cycles present zero data rather than whatever the
    // aliased RAM word happened to hold.
    assign s_axi.rdata   = (rvalid && fifo_resp[rd_ptr] == RESP_OKAY) ? fifo_data[rd_ptr] : '0;
    assign s_axi.rresp   = rvalid ? fifo_resp[rd_ptr] : RESP_OKAY;
    assign s_axi.rlast   = rvalid && fifo_last[rd_ptr];
    assign s_axi.rid     = r_id;

    // Inputs that are accepted but deliberately not used.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awaddr[BYTE_BITS-1:0], s_axi.awlen, s_axi.awsize,
                         s_axi.awburst, s_axi.awlock, s_axi.awcache, s_axi.awqos,
                         s_axi.awprot, s_axi.araddr[BYTE_BITS-1:0], s_axi.arsize,
                         s_axi.arburst, s_axi.arlock, s_axi.arcache, s_axi.arqos,
                         s_axi.arprot};

endmodule

// File: doc/abm_ram_slave.md
# abm_ram_slave

AXI4 slave responder that owns the ABM RAM buffer: it accepts INCR write bursts from a data-mover master, such as the host-to-ABM load path, into an on-chip dual-port RAM, and serves INCR read bursts back out. Write and read channels run independently, with one outstanding burst each. Full-rate read streaming is sustained under RREADY back-pressure by a 2-entry output buffer. The block sits on the ABM side of the interconnect as the target of the loader's destination AXI-MM port.

## Interface
- DW, 512, data width in bits; power of two, ≥ 32.
- AW, 64, address width.
- RAM_BYTES, 32'h10_0000, RAM size in bytes; power of two, multiple of DW/8. Depth = RAM_BYTES/(DW/8).
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWID  in  AW/8/3/2/4  write address.
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA/WSTRB/WLAST/WVALID  in  DW/(DW/8)/1/1  write data; S_AXI_WREADY out 1.
- S_AXI_BRESP/BID/BVALID  out  2/4/1  write response; S_AXI_BREADY in 1.
- S_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARID  in  AW/8/3/2/4  read address.
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA/RRESP/RID/RLAST/RVALID  out  DW/2/4/1/1  read data; S_AXI_RREADY in 1.
- S_AXI_AW/AR LOCK, CACHE, QOS, PROT  in  1/4/4/3  accepted and ignored.

## Operation
- Word index = addr[log2(RAM_BYTES)-1 : log2(DW/8)]. Low address bits are ignored, so transfers are treated as aligned.
- AxSIZE and AxBURST are ignored. Every burst is treated as INCR at full width, and the address advances DW/8 per beat.
- A beat is out of range when its byte address is ≥ RAM_BYTES.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE:
  - W_IDLE: AWREADY=1. An AW handshake captures the address, AWID, and an error flag cleared to 0, then moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes the WSTRB-enabled bytes to the RAM and increments the address.
    - Out-of-range beats are not written; they set the error flag.
    - A handshake with WLAST=1 moves to W_RESP. The beat count is taken from WLAST only; AWLEN is not checked.
  - W_RESP: BVALID=1, BID = captured AWID, BRESP = 2'b10 if the error flag is set, else 2'b00. A B handshake returns to W_IDLE.
- Read FSM R_IDLE → R_BURST → R_IDLE:
  - R_IDLE: ARREADY=1. An AR handshake captures the address, ARID, and a remaining count of ARLEN+1 (9-bit), then moves to R_BURST.
  - R_BURST: issue one RAM read per cycle while remaining > 0 and (buffered beats + in-flight reads) < 2. The RAM has 1-cycle read latency.
    - Each returned beat enters the 2-entry FIFO along with its RLAST flag (set on the final beat) and its RRESP.
    - An out-of-range beat returns RDATA=0, RRESP=2'b10. In-range beats return RRESP=2'b00. RID = captured ARID.
    - The FSM returns to R_IDLE on the R handshake of the RLAST beat.
- Simultaneous write and read to the same word in the same cycle: the read returns the old data.
- RAM contents are not affected by reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BRESP=0, BID=0, ARREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, RID=0.
- AWREADY and ARREADY rise on the first clk edge after reset deasserts.
- An AW handshake at cycle N gives AWREADY=0 and WREADY=1 at N+1.
- A WLAST handshake at cycle M gives WREADY=0 and BVALID=1 at M+1.
- After a B handshake at cycle K, AWREADY=1 at K+1.
- An AR handshake at cycle N gives the first RVALID at N+2.
- With RREADY held at 1, beats are delivered on consecutive cycles, so a burst of L beats ends with RLAST at N+1+L.
- RVALID, RDATA, RLAST, RRESP, and RID remain stable while RVALID=1 and RREADY=0. No beat is ever dropped or duplicated.
- After the RLAST handshake at cycle K, ARREADY=1 at K+1.
- Reset asserted mid-burst: both FSMs return immediately to their reset state and the FIFO is cleared. RAM beats already written are retained.

## Test plan
- Reset behaviour: assert reset while RVALID=1 mid-burst → every output goes to its reset value asynchronously; AWREADY and ARREADY are 1 one cycle after release.
- Write burst: AWADDR=0x1000, AWLEN=3, AWID=5, WDATA=beat index+1, WSTRB all ones, BREADY=1 → BVALID one cycle after the WLAST beat, BRESP=00, BID=5.
- Read back: ARADDR=0x1000, ARLEN=3, ARID=9, RREADY=1 → RVALID at N+2, data 1..4 on consecutive cycles, RLAST only on the 4th beat, RID=9, RRESP=00.
- Byte strobes: write all 0xAA to word 0, then write 0x55 with WSTRB=0x...000F → readback shows bytes 0–3 = 0x55 and the rest 0xAA.
- Back-pressure: ARLEN=255 with RREADY randomly 50% high → exactly 256 in-order beats, RLAST on beat 256 only, RDATA held stable during stalls.
- Out of range: AWADDR=0xFFFC0, AWLEN=1 → beat 0 written, beat 1 dropped, BRESP=10. Read of the same range → beat 0 with RRESP=00 and correct data, beat 1 with RRESP=10 and RDATA=0.
